// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared widths, limits and grant encoding for the RF port
//               scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int XLEN       = 32;
    localparam int REG_IDX_W  = 5;
    localparam int NREGS      = 32;
    localparam int STARVE_MAX = 2;
    localparam int STARVE_W   = 2;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_WR   = 2'd1,
        GRANT_RD   = 2'd2
    } grant_e;

endpackage
`default_nettype wire

// File: rtl/rf_arb.sv
`default_nettype none
// ============================================================================
// Module      : rf_arb
// Description : Read/write grant for the single register-file port, with a
//               starvation counter that lets a waiting read overtake writes.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_arb
    import rf_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   rd_req_valid,
    input  logic   rd_open,
    input  logic   wb_valid,
    output grant_e grant
);

    localparam logic [STARVE_W-1:0] C_STARVE_MAX = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] r_starve;
    logic                w_rd_elig;
    logic                w_rd_wins;

    always_comb begin
        w_rd_elig = rd_req_valid && rd_open;
        w_rd_wins = w_rd_elig && (!wb_valid || (r_starve == C_STARVE_MAX));
        grant     = GRANT_NONE;
        if (rst) begin
            grant = GRANT_NONE;
        end else if (w_rd_wins) begin
            grant = GRANT_RD;
        end else if (wb_valid) begin
            grant = GRANT_WR;
        end
    end

    // Counts reads that were ready to go but lost to a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (grant == GRANT_RD) begin
            r_starve <= '0;
        end else if (w_rd_elig && (r_starve != C_STARVE_MAX)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rf_port_sched.sv
`default_nettype none
// ============================================================================
// Module      : rf_port_sched
// Description : Sole driver of a single-port register file; schedules operand
//               reads and writebacks, forwards losing writes, holds responses.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_port_sched
    import rf_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_req_valid,
    output logic                 rd_req_ready,
    input  logic [REG_IDX_W-1:0] rd_req_rs1,
    input  logic [REG_IDX_W-1:0] rd_req_rs2,
    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic [REG_IDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [XLEN-1:0]      rsp_rs1v,
    output logic [XLEN-1:0]      rsp_rs2v,
    output logic                 rf_r,
    output logic [REG_IDX_W-1:0] rf_rs1,
    output logic [REG_IDX_W-1:0] rf_rs2,
    output logic [REG_IDX_W-1:0] rf_rd,
    output logic [XLEN-1:0]      rf_din,
    input  logic [XLEN-1:0]      rf_rs1v,
    input  logic [XLEN-1:0]      rf_rs2v
);

    grant_e          w_grant;
    logic            w_rd_open;
    logic            r_inflight;
    logic            r_rsp_valid;
    logic [XLEN-1:0] r_rsp_rs1v;
    logic [XLEN-1:0] r_rsp_rs2v;
    logic            r_zero1;
    logic            r_zero2;
    logic            r_fwd1;
    logic            r_fwd2;
    logic [XLEN-1:0] r_fwd_data;

    // A new read may start only if its response slot will be free on arrival.
    assign w_rd_open = !r_inflight && (!r_rsp_valid || rsp_ready);

    rf_arb u_arb (
        .clk          (clk),
        .rst          (rst),
        .rd_req_valid (rd_req_valid),
        .rd_open      (w_rd_open),
        .wb_valid     (wb_valid),
        .grant        (w_grant)
    );

    always_comb begin
        rf_r         = 1'b0;
        rf_rs1       = '0;
        rf_rs2       = '0;
        rf_rd        = '0;
        rf_din       = '0;
        wb_ready     = 1'b0;
        rd_req_ready = 1'b0;
        case (w_grant)
            GRANT_WR: begin
                wb_ready = 1'b1;
                rf_rd    = wb_rd;
                rf_din   = (wb_rd == '0) ? '0 : wb_data;
            end
            GRANT_RD: begin
                rd_req_ready = 1'b1;
                rf_r         = 1'b1;
                rf_rs1       = rd_req_rs1;
                rf_rs2       = rd_req_rs2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rs1v  <= '0;
            r_rsp_rs2v  <= '0;
            r_zero1     <= 1'b0;
            r_zero2     <= 1'b0;
            r_fwd1      <= 1'b0;
            r_fwd2      <= 1'b0;
            r_fwd_data  <= '0;
        end else begin
            r_inflight <= (w_grant == GRANT_RD);
            // A write pending at grant time loses the port, so its data is
            // captured here instead of waiting for the file to be updated.
            if (w_grant == GRANT_RD) begin
                r_zero1    <= (rd_req_rs1 == '0);
                r_zero2    <= (rd_req_rs2 == '0);
                r_fwd1     <= wb_valid && (wb_rd != '0) && (wb_rd == rd_req_rs1);
                r_fwd2     <= wb_valid && (wb_rd != '0) && (wb_rd == rd_req_rs2);
                r_fwd_data <= wb_data;
            end
            if (r_inflight) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rs1v  <= r_zero1 ? '0 : (r_fwd1 ? r_fwd_data : rf_rs1v);
                r_rsp_rs2v  <= r_zero2 ? '0 : (r_fwd2 ? r_fwd_data : rf_rs2v);
            end else if (r_rsp_valid && rsp_ready) begin
                r_rsp_valid <= 1'b0;
                r_rsp_rs1v  <= '0;
                r_rsp_rs2v  <= '0;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rs1v  = r_rsp_rs1v;
    assign rsp_rs2v  = r_rsp_rs2v;

endmodule
`default_nettype wire
